// File: rtl/gf2_poly_div_seq_if.sv
// Request/response bundle for the sequential GF(2)[x] long divider.
// master drives operands and consumes results; slave is the divider.
interface gf2_poly_div_seq_if #(
   parameter int N = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2*N-2:0]   dividend;
   logic [N-1:0]     divisor;
   logic             out_valid;
   logic             out_ready;
   logic [2*N-2:0]   quotient;
   logic [N-2:0]     remainder;
   logic             div_zero;

   modport master (
      output in_valid,
      output dividend,
      output divisor,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  quotient,
      input  remainder,
      input  div_zero
   );

   modport slave (
      input  in_valid,
      input  dividend,
      input  divisor,
      input  out_ready,
      output in_ready,
      output out_valid,
      output quotient,
      output remainder,
      output div_zero
   );
endinterface

// File: rtl/gf2_poly_div_seq.sv
// Sequential GF(2)[x] long divider, one quotient bit per cycle.
// Divisor is normalised so its top bit is set; remainder is shifted back.
module gf2_poly_div_seq #(
   parameter int N = 32
) (
   input  logic                clk,
   input  logic                rst,
   gf2_poly_div_seq_if.slave   bus
);
   localparam int QW = 2*N-1;
   localparam int RW = N-1;
   localparam int SW = $clog2(N);
   localparam int CW = $clog2(3*N-1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] DIV  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state;
   logic [QW-1:0] sreg;
   logic [RW-1:0] d_reg;
   logic [RW-1:0] r_reg;
   logic [QW-2:0] q_reg;
   logic [CW-1:0] cnt;
   logic [SW-1:0] s_reg;
   logic [QW-1:0] quot_q;
   logic [RW-1:0] rem_q;
   logic          dz_q;

   logic [SW-1:0] lz;
   logic [RW-1:0] d_low;
   logic [CW-1:0] cnt_init;
   logic [N-1:0]  t;
   logic          qb;
   logic [RW-1:0] r_nxt;
   logic [QW-1:0] q_nxt;

   // Highest set bit wins, giving the leading-zero count.
   always_comb begin
      lz = '0;
      for (int i = 0; i < N; i++) begin
         if (bus.divisor[i]) lz = SW'(N-1-i);
      end
   end

   // The normalised divisor's top bit is implicit, keep only the rest.
   assign d_low    = RW'(bus.divisor << lz);
   assign cnt_init = CW'(QW) + CW'(lz);

   assign t     = {r_reg, sreg[QW-1]};
   assign qb    = t[N-1];
   assign r_nxt = t[RW-1:0] ^ (qb ? d_reg : '0);
   assign q_nxt = {q_reg, qb};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sreg   <= '0;
         d_reg  <= '0;
         r_reg  <= '0;
         q_reg  <= '0;
         cnt    <= '0;
         s_reg  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dz_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (bus.divisor == '0) begin
                     quot_q <= '0;
                     rem_q  <= '0;
                     dz_q   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     sreg  <= bus.dividend;
                     d_reg <= d_low;
                     s_reg <= lz;
                     r_reg <= '0;
                     q_reg <= '0;
                     cnt   <= cnt_init;
                     state <= DIV;
                  end
               end
            end
            DIV: begin
               sreg  <= {sreg[QW-2:0], 1'b0};
               r_reg <= r_nxt;
               q_reg <= q_nxt[QW-2:0];
               cnt   <= cnt - 1'b1;
               if (cnt == CW'(1)) begin
                  quot_q <= q_nxt;
                  rem_q  <= r_nxt >> s_reg;
                  dz_q   <= 1'b0;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.div_zero  = dz_q;
endmodule
